// File: rtl/cam_capture_ctrl.sv
// OV7670 frame-capture controller: frame-aligned RGB565 byte pairing,
// RGB332 conversion and sequential framebuffer writes in the pixel-clock domain.
module cam_capture_ctrl #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              p_clock,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        p_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]  H_MAX = COL_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                phase_q, phase_d;
    logic [5:0]          hi_q, hi_d;
    logic                href_d_q, href_d_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        col_d        = col_q;
        line_d       = line_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        href_d_d     = href;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ARM;
                    overrun_d = 1'b0;
                end
            end
            S_ARM: begin
                if (vsync) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!vsync) begin
                    state_d = S_CAPTURE;
                    addr_d  = '0;
                    col_d   = '0;
                    line_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                // vsync beats a coincident href byte
                if (vsync) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end else if (href_d_q && !href) begin
                    line_d  = (line_q == V_MAX) ? line_q : line_q + LINE_W'(1);
                    col_d   = '0;
                    phase_d = 1'b0;
                end else if (href) begin
                    if (!phase_q) begin
                        hi_d    = {p_data[7:5], p_data[2:0]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < H_MAX && line_q < V_MAX) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = addr_q;
                            mem_data_d = {hi_q, p_data[4:3]};
                            addr_d     = addr_q + ADDR_W'(1);
                            col_d      = col_q + COL_W'(1);
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = cont ? S_SYNC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge p_clock) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            col_q        <= '0;
            line_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            href_d_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            line_q       <= line_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            href_d_q     <= href_d_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized self-checking bench for cam_capture_ctrl with a
// frame-level reference model and write scoreboard.
module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 15;

    logic          p_clock;
    logic          rst;
    logic          start;
    logic          cont;
    logic          vsync;
    logic          href;
    logic [7:0]    p_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    cam_capture_ctrl #(
        .H_PIXELS(H),
        .V_LINES (V),
        .ADDR_W  (AW)
    ) dut (
        .p_clock   (p_clock),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .vsync     (vsync),
        .href      (href),
        .p_data    (p_data),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    initial p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    int n_chk;
    int n_fail;

    // reference model state
    int           m_addr;
    int           m_line;
    bit           m_ovr;
    int           exp_addr_q[$];
    logic [7:0]   exp_data_q[$];

    // write log observed by the monitor
    logic [7:0]   wr_data_log[$];
    int           wr_addr_log[$];
    int           fd_cnt;
    bit           we_prev;
    int           wr_base;
    int           fd_base;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rgb332(input logic [7:0] hi,
                                          input logic [7:0] lo);
        int r, g, b;
        r = hi / 32;
        g = hi % 8;
        b = (lo / 8) % 4;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ovr = 1'b0;
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    endtask

    task automatic frame_body();
        m_addr  = 0;
        m_line  = 0;
        wr_base = wr_data_log.size();
        fd_base = fd_cnt;
        href    = 1'b0;
        vsync   = 1'b1;
        tick();
        tick();
        vsync   = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int nb, input bit gap, input bit fixed,
                             input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] hi;
        logic [7:0] d;
        hi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (fixed && i == 0) d = b0;
            else if (fixed && i == 1) d = b1;
            else d = 8'($urandom);
            href   = 1'b1;
            p_data = d;
            if (i % 2 == 0) begin
                hi = d;
            end else if (m_line < V && i / 2 < H) begin
                exp_addr_q.push_back(m_addr);
                exp_data_q.push_back(rgb332(hi, d));
                m_addr++;
            end else begin
                m_ovr = 1'b1;
            end
            tick();
        end
        if (gap) begin
            href = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            if (nb > 0) m_line++;
        end
    endtask

    task automatic end_frame(input bit collide, input bit cont_i);
        vsync  = 1'b1;
        cont   = cont_i;
        href   = collide;
        p_data = 8'($urandom);
        tick();
        chk("frame_done", {31'd0, frame_done}, 32'd1);
        href = 1'b0;
        tick();
        chk("busy_after", {31'd0, busy}, {31'd0, cont_i});
        chk("fd_pulses", fd_cnt - fd_base, 32'd1);
        chk("nwrites", wr_data_log.size() - wr_base, m_addr);
        chk("pending", exp_addr_q.size(), 32'd0);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        cont = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        fd_cnt = 0;
        we_prev = 1'b0;
        m_addr = 0;
        m_line = 0;
        m_ovr  = 1'b0;
        wr_base = 0;
        fd_base = 0;
        rst    = 1'b1;
        start  = 1'b0;
        cont   = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        p_data = 8'h00;

        fork
            forever begin
                @(negedge p_clock);
                if (mem_we === 1'b1) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("spurious_we", 32'd1, 32'd0);
                    end else begin
                        chk("wr_addr", 32'(mem_addr), exp_addr_q.pop_front());
                        chk("wr_data", {24'd0, mem_data},
                            {24'd0, exp_data_q.pop_front()});
                    end
                    wr_data_log.push_back(mem_data);
                    wr_addr_log.push_back(int'(mem_addr));
                    if (we_prev) chk("we_back2back", 32'd1, 32'd0);
                end
                we_prev = (mem_we === 1'b1);
                if (frame_done === 1'b1) fd_cnt++;
            end
        join_none

        // reset with toggling inputs
        for (int i = 0; i < 3; i++) begin
            start  = 1'($urandom);
            cont   = 1'($urandom);
            vsync  = 1'($urandom);
            href   = 1'($urandom);
            p_data = 8'($urandom);
            tick();
            chk("reset_outs", {5'd0, mem_addr, mem_data, mem_we, busy,
                               frame_done, overrun}, 32'd0);
        end
        rst = 1'b0; start = 1'b0; cont = 1'b0;
        vsync = 1'b0; href = 1'b0;
        tick();
        chk("post_reset", {5'd0, mem_addr, mem_data, mem_we, busy,
                           frame_done, overrun}, 32'd0);

        // single directed frame
        do_start();
        frame_body();
        send_line(8, 1'b1, 1'b1, 8'hF8, 8'h1F);
        send_line(8, 1'b1, 1'b0, 8'h00, 8'h00);
        end_frame(1'b0, 1'b0);
        chk("first_px", {24'd0, wr_data_log[wr_base]}, 32'hE3);

        // start mid-frame: nothing may be written before a vsync cycle
        vsync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start  = (i == 0);
            href   = 1'b1;
            p_data = 8'($urandom);
            tick();
        end
        start = 1'b0;
        m_ovr = 1'b0;
        chk("busy_armed", {31'd0, busy}, 32'd1);
        href = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            href = 1'b1;
            p_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        tick();
        frame_body();
        send_line(4, 1'b1, 1'b0, 8'h00, 8'h00);
        end_frame(1'b0, 1'b0);
        chk("first_addr", wr_addr_log[wr_base], 32'd0);

        // overrun: 6-pixel line, then next line starts at addr 4
        do_start();
        frame_body();
        send_line(12, 1'b1, 1'b0, 8'h00, 8'h00);
        send_line(8, 1'b1, 1'b0, 8'h00, 8'h00);
        end_frame(1'b0, 1'b0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        chk("line2_addr", wr_addr_log[wr_base + 4], 32'd4);

        // odd byte followed by vsync colliding with href
        do_start();
        frame_body();
        send_line(7, 1'b0, 1'b0, 8'h00, 8'h00);
        end_frame(1'b1, 1'b0);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            do_start();
            frame_body();
            repeat ($urandom_range(1, 3))
                send_line($urandom_range(0, 12), 1'b1, 1'b0, 8'h00, 8'h00);
            end_frame(1'b0, 1'b0);
        end

        // continuous mode, then reset mid frame 2
        do_start();
        frame_body();
        send_line(8, 1'b1, 1'b0, 8'h00, 8'h00);
        send_line(6, 1'b1, 1'b0, 8'h00, 8'h00);
        end_frame(1'b0, 1'b1);
        frame_body();
        send_line(4, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("cont_restart", wr_addr_log[wr_base], 32'd0);
        href   = 1'b1;
        p_data = 8'($urandom);
        tick();
        rst    = 1'b1;
        p_data = 8'($urandom);
        tick();
        chk("rst_no_we", {31'd0, mem_we}, 32'd0);
        chk("rst_outs", {5'd0, mem_addr, mem_data, mem_we, busy,
                         frame_done, overrun}, 32'd0);
        rst  = 1'b0;
        href = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vsync = (i % 3 == 0);
            href  = (i % 3 == 2);
            tick();
        end
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        chk("pending_final", exp_addr_q.size(), 32'd0);
        chk("writes_after_rst", wr_data_log.size() - wr_base, 32'd2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
